// File: rtl/boost_pkg.sv
// Shared widths, defaults and FSM encoding for the boost PI duty controller.
package boost_pkg;

    localparam int FRAC_DEF = 8;
    localparam int ADC_W    = 12;
    localparam int DUTY_W   = 10;
    localparam int ERR_W    = 13;
    localparam int ACC_W    = 20;
    localparam int MUL_W    = 30;
    localparam int SUM_W    = 31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAP,
        S_ERR,
        S_MUL,
        S_ACC,
        S_SUM,
        S_OUT
    } state_t;

    typedef struct packed {
        logic [ADC_W-1:0] v_ref;
        logic [ADC_W-1:0] v_meas;
    } sample_t;

endpackage

// File: rtl/sat_clamp.sv
// Signed clamp of an IW-bit value to [lo, hi], truncated to OW bits (lo/hi must fit OW).
module sat_clamp #(
    parameter int IW = 31,
    parameter int OW = 20
) (
    input  logic signed [IW-1:0] x,
    input  logic signed [IW-1:0] lo,
    input  logic signed [IW-1:0] hi,
    output logic        [OW-1:0] y
);

    always_comb begin
        y = OW'(x);
        if (x < lo)
            y = OW'(lo);
        else if (x > hi)
            y = OW'(hi);
    end

endmodule

// File: rtl/boost_pi_ctrl.sv
// Per-period PI update of the boost duty word: capture, error, multiply, clamped
// integrate, sum, saturate. One stage per FSM state; integrator commits only on output.
module boost_pi_ctrl
    import boost_pkg::*;
#(
    parameter logic [15:0]       KP     = 16'd256,
    parameter logic [15:0]       KI     = 16'd16,
    parameter int                FRAC   = FRAC_DEF,
    parameter logic [DUTY_W-1:0] DMIN   = 10'd0,
    parameter logic [DUTY_W-1:0] DMAX   = 10'd900,
    parameter logic [DUTY_W-1:0] D_INIT = 10'd500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              sample,
    input  logic [ADC_W-1:0]  v_meas,
    input  logic [ADC_W-1:0]  v_ref,
    output logic [DUTY_W-1:0] d_out,
    output logic              valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic signed [SUM_W-1:0] ACC_LO  = SUM_W'(DMIN) << FRAC;
    localparam logic signed [SUM_W-1:0] ACC_HI  = SUM_W'(DMAX) << FRAC;
    localparam logic signed [SUM_W-1:0] OUT_LO  = SUM_W'(DMIN);
    localparam logic signed [SUM_W-1:0] OUT_HI  = SUM_W'(DMAX);
    localparam logic signed [ACC_W-1:0] ACC_RST = ACC_W'(int'(D_INIT) << FRAC);

    state_t                    state, state_nxt;
    logic                      sample_q, armed, trigger, commit;
    sample_t                   cap_q;
    logic signed [ERR_W-1:0]   e_q;
    logic signed [MUL_W-1:0]   p_q, i_q;
    logic signed [SUM_W-1:0]   acc_sum, u_sum, u_q;
    logic signed [ACC_W-1:0]   acc, acc_n, acc_n_q;
    logic        [DUTY_W-1:0]  d_sat;

    // armed stays low for the first cycle after reset so that a sample line
    // already high at release is seen as a level, not a fresh edge.
    assign trigger = sample & ~sample_q & ce & armed;
    assign busy    = (state != S_IDLE);

    assign acc_sum = SUM_W'(acc) + SUM_W'(i_q);
    assign u_sum   = SUM_W'(p_q) + SUM_W'(acc_n_q);

    sat_clamp #(.IW(SUM_W), .OW(ACC_W)) u_acc_clamp (
        .x  (acc_sum),
        .lo (ACC_LO),
        .hi (ACC_HI),
        .y  (acc_n)
    );

    sat_clamp #(.IW(SUM_W), .OW(DUTY_W)) u_out_clamp (
        .x  (u_q),
        .lo (OUT_LO),
        .hi (OUT_HI),
        .y  (d_sat)
    );

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        if (!ce) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (trigger) state_nxt = S_CAP;
                S_CAP:   state_nxt = S_ERR;
                S_ERR:   state_nxt = S_MUL;
                S_MUL:   state_nxt = S_ACC;
                S_ACC:   state_nxt = S_SUM;
                S_SUM:   state_nxt = S_OUT;
                S_OUT: begin
                    commit    = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sample_q <= 1'b0;
            armed    <= 1'b0;
            overrun  <= 1'b0;
            valid    <= 1'b0;
            d_out    <= D_INIT;
            acc      <= ACC_RST;
        end else begin
            state    <= state_nxt;
            sample_q <= sample;
            armed    <= 1'b1;
            valid    <= commit;
            if (trigger && busy)
                overrun <= 1'b1;
            if (commit) begin
                d_out <= d_sat;
                acc   <= acc_n_q;
            end
        end
    end

    // Datapath stages carry no reset; each is written before it is consumed.
    always_ff @(posedge clk) begin
        if (ce) begin
            case (state)
                S_CAP: begin
                    cap_q.v_ref  <= v_ref;
                    cap_q.v_meas <= v_meas;
                end
                S_ERR: e_q <= $signed({1'b0, cap_q.v_ref}) - $signed({1'b0, cap_q.v_meas});
                S_MUL: begin
                    p_q <= MUL_W'($signed({1'b0, KP})) * MUL_W'(e_q);
                    i_q <= MUL_W'($signed({1'b0, KI})) * MUL_W'(e_q);
                end
                S_ACC: acc_n_q <= acc_n;
                S_SUM: u_q     <= u_sum >>> FRAC;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boost_pi_ctrl.sv
// Directed bench for boost_pi_ctrl: latency, PI arithmetic, anti-windup, overrun, reset and ce aborts.
module tb_boost_pi_ctrl;

    logic        clk = 1'b0;
    logic        rst, ce, sample;
    logic [11:0] v_meas, v_ref;
    logic [9:0]  d_out;
    logic        valid, busy, overrun;
    int          total = 0;
    int          bad   = 0;
    int          seen;

    always #5 clk = ~clk;

    boost_pi_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .sample  (sample),
        .v_meas  (v_meas),
        .v_ref   (v_ref),
        .d_out   (d_out),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full update: edge at cycle 0, inputs scrambled after capture, result at cycle 6.
    task automatic run_update(input logic [11:0] r, input logic [11:0] m, input logic [9:0] exp_d,
                              input int exp_acc, input bit second, input string tag);
        int nv;
        nv = 0;
        @(negedge clk) sample = 1'b0;
        @(negedge clk) begin v_ref = r; v_meas = m; sample = 1'b1; end
        @(negedge clk);
        chk({tag, ":busy_c0"}, 32'(busy), 1);
        sample = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (valid) nv++;
            if (k == 1) begin v_ref = 12'($urandom); v_meas = 12'($urandom); end
            if (second && k == 2) sample = 1'b1;
            if (k == 5) chk({tag, ":busy_c5"}, 32'(busy), 1);
        end
        @(negedge clk);
        chk({tag, ":valid_c6"}, 32'(valid), 1);
        chk({tag, ":d_out"}, 32'(d_out), 32'(exp_d));
        chk({tag, ":busy_c6"}, 32'(busy), 0);
        chk({tag, ":acc"}, 32'(dut.acc), exp_acc);
        repeat (3) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk({tag, ":extra_valid"}, 32'(nv), 0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; sample = 1'b0; v_ref = '0; v_meas = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst:d_out", 32'(d_out), 500);
        chk("rst:valid", 32'(valid), 0);
        chk("rst:busy", 32'(busy), 0);
        chk("rst:overrun", 32'(overrun), 0);
        chk("rst:acc", 32'(dut.acc), 128000);

        run_update(12'd2000, 12'd2000, 10'd500, 128000, 1'b0, "zero_err");
        chk("zero_err:overrun", 32'(overrun), 0);
        run_update(12'd2100, 12'd2000, 10'd606, 129600, 1'b0, "e100");
        run_update(12'd4095, 12'd0, 10'd900, 195120, 1'b0, "sat1");
        run_update(12'd4095, 12'd0, 10'd900, 230400, 1'b0, "sat2");
        run_update(12'd4095, 12'd0, 10'd900, 230400, 1'b0, "sat3");
        run_update(12'd1000, 12'd1000, 10'd900, 230400, 1'b0, "hold");
        run_update(12'd0, 12'd4095, 10'd0, 164880, 1'b1, "neg");
        chk("neg:overrun", 32'(overrun), 1);

        // reset during cycle 4 of an update, sample held high across release
        @(negedge clk) sample = 1'b0;
        @(negedge clk) begin v_ref = 12'd2100; v_meas = 12'd2000; sample = 1'b1; end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst:d_out", 32'(d_out), 500);
        chk("midrst:valid", 32'(valid), 0);
        chk("midrst:busy", 32'(busy), 0);
        chk("midrst:overrun", 32'(overrun), 0);
        chk("midrst:acc", 32'(dut.acc), 128000);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || valid) seen++;
        end
        chk("midrst:no_retrig", 32'(seen), 0);

        // trigger with ce low
        sample = 1'b0; ce = 1'b0;
        @(negedge clk) sample = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || valid) seen++;
        end
        chk("ce0:activity", 32'(seen), 0);
        chk("ce0:d_out", 32'(d_out), 500);

        // ce dropped mid-update aborts without committing
        sample = 1'b0; ce = 1'b1;
        @(negedge clk) begin v_ref = 12'd2100; v_meas = 12'd2000; sample = 1'b1; end
        @(negedge clk);
        chk("abort:busy_c0", 32'(busy), 1);
        sample = 1'b0;
        repeat (2) @(negedge clk);
        ce = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid) seen++;
        end
        chk("abort:valid", 32'(seen), 0);
        chk("abort:busy", 32'(busy), 0);
        chk("abort:d_out", 32'(d_out), 500);
        chk("abort:acc", 32'(dut.acc), 128000);
        ce = 1'b1;

        run_update(12'd2100, 12'd2000, 10'd606, 129600, 1'b0, "recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
